branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Registered RV32I branch resolution stage with a built-in branch history table (BHT) of 2-bit saturating counters.
- Fetch side: combinational taken/not-taken prediction indexed by PC.
- Execute side: evaluates all six RV32I branch conditions, updates the BHT, and flags mispredictions with a redirect PC one cycle later.
- Sits between decode/execute and the fetch PC mux.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, number of counters; power of two, minimum 2.
- IDX_LSB, 2, lowest PC bit used for the BHT index. Index = pc[IDX_LSB +: log2(BHT_ENTRIES)].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pred_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  MSB of the indexed counter (combinational).
- res_valid  in  1  resolve request this cycle.
- res_branch_en  in  1  instruction is a conditional branch.
- res_funct3  in  3  branch funct3.
- res_op_a  in  XLEN  rs1 value.
- res_op_b  in  XLEN  rs2 value.
- res_pc  in  XLEN  branch PC.
- res_target  in  XLEN  computed branch target.
- res_pred_taken  in  1  prediction carried from fetch.
- stall  in  1  hold the stage.
- flush  in  1  kill the stage.
- out_valid  out  1  result valid.
- out_taken  out  1  resolved direction.
- out_mispredict  out  1  resolved direction differs from res_pred_taken.
- out_redirect_pc  out  XLEN  correct next PC, meaningful only when out_mispredict=1.
- out_illegal  out  1  funct3 was 010 or 011.

Behaviour:
- Reset (async, rst_n=0): out_valid, out_taken, out_mispredict, out_illegal all 0; out_redirect_pc = 0; every BHT counter = 2'b01 (WNT). Reset mid-operation discards any in-flight result.
- Conditions:
  - BEQ 000: a==b.
  - BNE 001: a!=b.
  - BLT 100: signed a<b.
  - BGE 101: signed a>=b.
  - BLTU 110: unsigned a<b.
  - BGEU 111: unsigned a>=b.
  - 010/011: taken=0, out_illegal=1, no BHT update.
- Accept: when res_valid=1 and res_branch_en=1, the result is registered at the next edge (latency 1).
  - res_valid=1 with res_branch_en=0: out_valid=1, out_taken=0, mispredict = res_pred_taken, redirect = res_pc+4, no BHT update.
- Redirect:
  - Taken and predicted not-taken: out_redirect_pc = res_target.
  - Not taken and predicted taken: out_redirect_pc = res_pc+4, computed mod 2^XLEN; PC 0xFFFFFFFC wraps to 0.
- Counter FSM per entry: SNT 00, WNT 01, WT 10, ST 11.
  - Taken: increment, saturating at ST.
  - Not taken: decrement, saturating at SNT.
  - Update happens at the same edge the result is registered.
- Predict/update collision on the same index in the same cycle: pred_taken reflects the pre-update value. No forwarding.
- stall=1: all out_* registers hold, no BHT update, and res_* inputs are ignored. The upstream stage holds its inputs.
- flush=1: out_valid=0 at the next edge and the same-cycle BHT update is suppressed. flush has priority over stall.
- With out_valid=0, the other out_* registers hold their last values; consumers qualify them with out_valid.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined: adds two 32-bit counters, stat_branches and stat_mispredicts, exposed as output ports.
  - Each increments on every registered branch (res_branch_en=1, not flushed, not stalled), and on mispredicts respectively.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Not defined: the ports still exist and are tied to 0; no flops are inferred.

Decomposition:
- Package bru_pkg holds:
  - funct3 constants F3_BEQ..F3_BGEU;
  - counter encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST;
  - CTR_RESET = CTR_WNT.
- Sub-module bht_2bit: the counter array with an async reset, one combinational read port, and one saturating-update write port (wr_en, wr_idx, wr_taken).

Test Plan:
- Reset, then set pred_pc=0x100 -> pred_taken=0; all out_* = 0.
- BLTU with a=0xFFFFFFFF, b=1, pred=1 -> out_taken=0, out_mispredict=1, out_redirect_pc = res_pc+4. BLT on the same operands, pred=0 -> taken=1, redirect = res_target.
- Three consecutive taken BEQ at pc=0x40 -> counter goes 01→10→11→11; pred_taken=1 after the first update. Two not-taken -> 11→10→01, pred_taken=0.
- Predict and update on the same index in one cycle -> pred_taken shows the old value; the new value is visible next cycle.
- stall asserted with a valid resolve -> outputs unchanged and counter unchanged. stall and flush together -> out_valid=0 next cycle and no update.
- funct3=010 -> out_illegal=1, taken=0, BHT unchanged. res_pc=0xFFFFFFFC, not taken, pred=1 -> redirect = 0x00000000.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared constants for the branch resolve unit: RV32I branch funct3 codes,
// 2-bit predictor counter encodings and the saturating counter step.
package bru_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = CTR_WNT;

    // One step of the saturating counter walk SNT <-> WNT <-> WT <-> ST.
    function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

    // funct3 values 010 and 011 are not branch encodings.
    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with one combinational
// read port and one saturating-update write port.
module bht_2bit
    import bru_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    ctr_e ctr_q [ENTRIES];
    ctr_e ctr_d [ENTRIES];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) begin
            ctr_d[wr_idx] = ctr_next(ctr_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // Reads the registered value, so a same-cycle update is not forwarded.
    assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// RV32I branch resolution stage with an integrated 2-bit BHT predictor.
// Optional statistics counters are enabled with the BRU_STATS_EN macro.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_LSB     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_branch_en,
    input  logic [2:0]      res_funct3,
    input  logic [XLEN-1:0] res_op_a,
    input  logic [XLEN-1:0] res_op_b,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_pred_taken,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic            out_illegal,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic            cond_taken;
    logic            f3_illegal;
    logic            res_taken;
    logic            res_illegal;
    logic            res_mispredict;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_pc;
    logic            accept;
    logic            bht_wr_en;
    logic            unused_pred_pc;

    always_comb begin
        cond_taken = 1'b0;
        case (res_funct3)
            F3_BEQ:  cond_taken = (res_op_a == res_op_b);
            F3_BNE:  cond_taken = (res_op_a != res_op_b);
            F3_BLT:  cond_taken = ($signed(res_op_a) <  $signed(res_op_b));
            F3_BGE:  cond_taken = ($signed(res_op_a) >= $signed(res_op_b));
            F3_BLTU: cond_taken = (res_op_a <  res_op_b);
            F3_BGEU: cond_taken = (res_op_a >= res_op_b);
            default: cond_taken = 1'b0;
        endcase
    end

    // Non-branch resolves are treated as not-taken and never touch the BHT.
    assign f3_illegal     = is_illegal_f3(res_funct3);
    assign res_taken      = res_branch_en & cond_taken;
    assign res_illegal    = res_branch_en & f3_illegal;
    assign res_mispredict = (res_taken != res_pred_taken);
    assign pc_plus4       = res_pc + XLEN'(4);
    assign redirect_pc    = res_taken ? res_target : pc_plus4;

    assign accept    = res_valid & ~stall & ~flush;
    assign bht_wr_en = accept & res_branch_en & ~f3_illegal;

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pred_pc[IDX_LSB +: IDX_W]),
        .rd_taken (pred_taken),
        .wr_en    (bht_wr_en),
        .wr_idx   (res_pc[IDX_LSB +: IDX_W]),
        .wr_taken (res_taken)
    );

    assign unused_pred_pc = ^pred_pc;

    // flush beats stall; an idle cycle only drops out_valid so payload holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_taken       <= 1'b0;
            out_mispredict  <= 1'b0;
            out_redirect_pc <= '0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            if (res_valid) begin
                out_valid       <= 1'b1;
                out_taken       <= res_taken;
                out_mispredict  <= res_mispredict;
                out_redirect_pc <= redirect_pc;
                out_illegal     <= res_illegal;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef BRU_STATS_EN
    logic count_branch;
    assign count_branch = accept & res_branch_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (count_branch) begin
            if (stat_branches != 32'hFFFF_FFFF) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (res_mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases followed by
// randomized resolves compared against a behavioural predictor model.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic        res_branch_en;
    logic [2:0]  res_funct3;
    logic [31:0] res_op_a;
    logic [31:0] res_op_b;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        out_taken;
    logic        out_mispredict;
    logic [31:0] out_redirect_pc;
    logic        out_illegal;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_resolve_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_branch_en    (res_branch_en),
        .res_funct3       (res_funct3),
        .res_op_a         (res_op_a),
        .res_op_b         (res_op_b),
        .res_pc           (res_pc),
        .res_target       (res_target),
        .res_pred_taken   (res_pred_taken),
        .stall            (stall),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_taken        (out_taken),
        .out_mispredict   (out_mispredict),
        .out_redirect_pc  (out_redirect_pc),
        .out_illegal      (out_illegal),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state: counter strength 0..3 per entry and expected outputs.
    int          model_ctr [64];
    logic        exp_valid, exp_taken, exp_misp, exp_illegal;
    logic [31:0] exp_redirect;
    logic [31:0] exp_stat_b, exp_stat_m;

    function automatic int bhtIndex(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic logic modelPredict(input logic [31:0] pc);
        return (model_ctr[bhtIndex(pc)] >= 2);
    endfunction

    function automatic logic refTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 64; i++) model_ctr[i] = 1;
        exp_valid = 0; exp_taken = 0; exp_misp = 0; exp_illegal = 0;
        exp_redirect = 0; exp_stat_b = 0; exp_stat_m = 0;
    endtask

    task automatic modelStep();
        logic t;
        logic bad;
        if (flush) begin
            exp_valid = 0;
        end else if (!stall) begin
            if (!res_valid) begin
                exp_valid = 0;
            end else if (!res_branch_en) begin
                exp_valid = 1; exp_taken = 0; exp_illegal = 0;
                exp_misp = res_pred_taken;
                exp_redirect = res_pc + 32'd4;
            end else begin
                bad = (res_funct3 == 3'd2) || (res_funct3 == 3'd3);
                t = refTaken(res_funct3, res_op_a, res_op_b);
                exp_valid = 1; exp_taken = t; exp_illegal = bad;
                exp_misp = (t != res_pred_taken);
                exp_redirect = t ? res_target : res_pc + 32'd4;
                exp_stat_b = exp_stat_b + 1;
                if (exp_misp) exp_stat_m = exp_stat_m + 1;
                if (!bad) begin
                    if (t && model_ctr[bhtIndex(res_pc)] < 3) model_ctr[bhtIndex(res_pc)]++;
                    if (!t && model_ctr[bhtIndex(res_pc)] > 0) model_ctr[bhtIndex(res_pc)]--;
                end
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        checkValue("out_taken", {31'b0, out_taken}, {31'b0, exp_taken});
        checkValue("out_mispredict", {31'b0, out_mispredict}, {31'b0, exp_misp});
        checkValue("out_illegal", {31'b0, out_illegal}, {31'b0, exp_illegal});
        if (exp_misp) checkValue("out_redirect_pc", out_redirect_pc, exp_redirect);
        checkValue("pred_taken", {31'b0, pred_taken}, {31'b0, modelPredict(pred_pc)});
`ifdef BRU_STATS_EN
        checkValue("stat_branches", stat_branches, exp_stat_b);
        checkValue("stat_mispredicts", stat_mispredicts, exp_stat_m);
`else
        checkValue("stat_branches", stat_branches, 32'd0);
        checkValue("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    endtask

    // Drive one cycle of inputs, check the pre-edge prediction, then the result.
    task automatic applyStimulus(input logic v, input logic br, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic pt, input logic st, input logic fl,
                                 input logic [31:0] ppc);
        res_valid = v; res_branch_en = br; res_funct3 = f3;
        res_op_a = a; res_op_b = b; res_pc = pc; res_target = tgt;
        res_pred_taken = pt; stall = st; flush = fl; pred_pc = ppc;
        #2;
        checkValue("pred_taken_pre_edge", {31'b0, pred_taken}, {31'b0, modelPredict(pred_pc)});
        @(posedge clk);
        #1;
        modelStep();
        checkOutput();
    endtask

    initial begin
        logic [31:0] a, b, pc;
        logic        v, br, st, fl, pt;
        rst_n = 1'b0;
        res_valid = 0; res_branch_en = 0; res_funct3 = 0; res_op_a = 0; res_op_b = 0;
        res_pc = 0; res_target = 0; res_pred_taken = 0; stall = 0; flush = 0;
        pred_pc = 32'h100;
        modelReset();
        #1;
        checkOutput();
        checkValue("reset_redirect", out_redirect_pc, 32'd0);
        #13;
        rst_n = 1'b1;

        // Unsigned vs signed on the same operands
        applyStimulus(1, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1, 0, 0, 32'h200);
        checkValue("bltu_redirect", out_redirect_pc, 32'h204);
        applyStimulus(1, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 0, 0, 0, 32'h200);
        checkValue("blt_redirect", out_redirect_pc, 32'h300);

        // Counter training at 0x40: three taken then two not-taken
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1, 3'b000, 32'd5, 32'd5, 32'h40, 32'h80, modelPredict(32'h40), 0, 0, 32'h40);
        checkValue("beq_strong_taken", {31'b0, pred_taken}, 32'd1);
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 1, 3'b000, 32'd5, 32'd6, 32'h40, 32'h80, modelPredict(32'h40), 0, 0, 32'h40);
        checkValue("beq_back_to_wnt", {31'b0, pred_taken}, 32'd0);

        // Stall with a valid resolve, then stall and flush together
        applyStimulus(1, 1, 3'b001, 32'd1, 32'd2, 32'h40, 32'h90, 0, 1, 0, 32'h40);
        applyStimulus(1, 1, 3'b001, 32'd1, 32'd2, 32'h40, 32'h90, 0, 1, 1, 32'h40);
        applyStimulus(0, 0, 3'b000, 32'd0, 32'd0, 32'h40, 32'h0, 0, 0, 0, 32'h40);

        // Illegal funct3 and PC wrap on the fall-through redirect
        applyStimulus(1, 1, 3'b010, 32'd7, 32'd7, 32'h40, 32'h44, 1, 0, 0, 32'h40);
        applyStimulus(1, 1, 3'b011, 32'd7, 32'd8, 32'h40, 32'h44, 0, 0, 0, 32'h40);
        applyStimulus(1, 1, 3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h10, 1, 0, 0, 32'h40);
        checkValue("wrap_redirect", out_redirect_pc, 32'h0000_0000);
        applyStimulus(1, 0, 3'b000, 32'd1, 32'd1, 32'h500, 32'h10, 1, 0, 0, 32'h500);
        applyStimulus(0, 1, 3'b000, 32'd1, 32'd1, 32'h500, 32'h10, 1, 0, 0, 32'h500);

        // Randomized resolves over a small index pool to force collisions
        for (int n = 0; n < 400; n++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
            pc = $urandom & 32'hFFFF_F03C;
            v  = ($urandom_range(0, 7) != 0);
            br = ($urandom_range(0, 7) != 0);
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 9) == 0);
            pt = ($urandom_range(0, 3) == 0) ? 1'($urandom) : modelPredict(pc);
            applyStimulus(v, br, 3'($urandom), a, b, pc, $urandom & 32'hFFFF_FFFC, pt, st, fl,
                          ($urandom_range(0, 1) == 0) ? pc : ($urandom & 32'h0000_003C));
            if (n == 200) begin
                #2;
                rst_n = 1'b0;
                #1;
                modelReset();
                checkOutput();
                #1;
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
